pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised successor to the single D flip-flop: a DEPTH-stage chain of
//   WIDTH-bit registers with a per-stage valid bit and valid/ready flow control.
//   Bubbles collapse, and a stall at the output back-pressures only the stages that are full.
//   Sits between any two valid/ready blocks as a retiming/latency stage.
//   Also provides a synchronous flush and an occupancy count.
// PARAMETERS
//   WIDTH       8   data width in bits (>=1)
//   DEPTH       4   number of register stages (>=1)
//   RESET_DATA  0   value loaded into every data register on rst
// PORTS
//   clk        in   1                    rising-edge clock
//   rst        in   1                    synchronous, active-high reset
//   flush      in   1                    synchronous clear of all valid bits
//   in_valid   in   1                    upstream beat present
//   in_ready   out  1                    chain accepts a beat this cycle
//   in_data    in   WIDTH                upstream data
//   out_valid  out  1                    last stage holds a beat
//   out_ready  in   1                    downstream accepts a beat
//   out_data   out  WIDTH                last-stage data
//   occupancy  out  $clog2(DEPTH+1)      number of valid stages, 0..DEPTH
// BEHAVIOUR
//   - Stage i (0..DEPTH-1) holds v[i] and d[i]. Stage DEPTH-1 drives out_valid/out_data.
//   - Ready chain (combinational):
//     - rdy[DEPTH] = out_ready
//     - rdy[i] = !v[i] | rdy[i+1]
//     - in_ready = rdy[0] & !flush & !rst
//   - Per clock edge, evaluated from DEPTH-1 down to 0:
//     - If rdy[i], stage i loads the previous stage's v and d.
//     - Stage 0 loads in_valid&in_ready and in_data.
//     - Otherwise stage i holds its v and d.
//     - d[i] loads only when the incoming valid is 1; otherwise d[i] holds.
//   - Transfers: in_valid&in_ready = one accepted beat. out_valid&out_ready = one delivered beat.
//   - Latency: empty chain with out_ready=1:
//     - A beat accepted at edge t shows out_valid=1 after edge t+DEPTH-1.
//     - This is DEPTH cycles from input presentation.
//     - Throughput is 1 beat/cycle.
//   - Stall: while out_valid=1 and out_ready=0, out_data holds stable.
//     - Upstream stages keep filling until every stage is valid; then in_ready=0.
//   - Full chain with out_ready=1: in_ready=1 in the same cycle, so there is no bubble.
//   - Empty chain: out_valid=0 and out_data holds its last value (don't-care for consumers).
//   - Ordering: beats exit in acceptance order. There is no loss and no duplication.
//   - Occupancy:
//     - occupancy = popcount(v), registered-consistent with v.
//     - It reaches DEPTH when full and 0 when empty.
//   - Flush (rst=0, flush=1):
//     - All v go to 0 at the edge, and the occupancy count goes to 0.
//     - d is unchanged.
//     - in_ready=0 that cycle, so no beat is accepted.
//     - A beat delivered downstream in the flush cycle (out_valid&out_ready) still counts as delivered.
//   - Reset (rst=1):
//     - All v=0 and all d=RESET_DATA at the edge.
//     - Outputs after that edge: out_valid=0, out_data=RESET_DATA, occupancy=0.
//     - in_ready=0 while rst=1.
//     - rst has priority over flush and over any transfer, including mid-stream.
//   - DEPTH=1: in_ready = !v[0] | out_ready. This is a single pipeline register.
// TESTING
//   1 Reset: rst=1 for 2 edges with in_valid=1, in_data=8'hAA
//     -> out_valid=0, out_data=8'h00, occupancy=0, in_ready=0.
//   2 Stream: DEPTH=4, out_ready=1, send 8'h01..8'h08 on consecutive cycles
//     -> first out_valid 4 cycles after first in_valid; 01..08 exit on consecutive cycles.
//   3 Stall: out_ready=0, send 8'h10..8'h15
//     -> in_ready drops after 4 accepts; occupancy=4; out_data=8'h10 stable.
//     -> Then out_ready=1: in_ready=1 in the same cycle; 10..15 exit in order.
//   4 Bubbles: send 8'h21, idle 2 cycles, send 8'h22, with out_ready=0
//     -> both collapse into stages 3 and 2; occupancy=2.
//   5 Flush: chain holding 3 beats, pulse flush with in_valid=1
//     -> next cycle out_valid=0, occupancy=0; the flush-cycle input is not accepted.
//   6 Random: random in_valid/out_ready for 2000 cycles with scoreboard
//     -> no loss, no duplication, in order; stalled out_data stable; occupancy matches the model.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//   DEPTH-stage chain of WIDTH-bit registers, each with its own valid bit,
//   under valid/ready flow control. Empty stages absorb bubbles, so a stall at
//   the output only holds stages that are full. Provides a synchronous flush
//   of all valid bits and a registered occupancy count.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over flush/transfers)
//   flush      synchronous clear of all valid bits (data registers untouched)
//   in_valid   upstream beat present
//   in_ready   chain accepts a beat this cycle (combinational)
//   in_data    upstream data
//   out_valid  last stage holds a beat
//   out_ready  downstream accepts a beat
//   out_data   last-stage data
//   occupancy  number of valid stages, 0..DEPTH
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      DEPTH      = 4,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   // rdy[i]: stage i may take a new value this cycle; rdy[DEPTH] is downstream
   logic [DEPTH:0]   rdy;
   // Value offered to each stage by its predecessor (stage 0: the input port)
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];

   assign rdy[DEPTH] = out_ready;

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
      // A stage can move if it is empty or everything ahead of it can move
      assign rdy[g] = ~v_q[g] | rdy[g+1];

      if (g == 0) begin : g_head
         assign src_v[g] = in_valid & in_ready;
         assign src_d[g] = in_data;
      end else begin : g_body
         assign src_v[g] = v_q[g-1];
         assign src_d[g] = d_q[g-1];
      end
   end

   assign in_ready = rdy[0] & ~flush & ~rst;

   // Next-state for every stage plus the matching occupancy count
   always_comb begin
      v_d   = v_q;
      d_d   = d_q;
      occ_d = '0;

      for (int i = 0; i < int'(DEPTH); i++) begin
         if (rdy[i]) begin
            v_d[i] = src_v[i];
            // Data only moves with a real beat; bubbles leave the old value
            if (src_v[i]) begin
               d_d[i] = src_d[i];
            end
         end
      end

      // Flush drops every beat but leaves the data registers as they were
      if (flush) begin
         v_d = '0;
         d_d = d_q;
      end

      for (int i = 0; i < int'(DEPTH); i++) begin
         occ_d = occ_d + OCC_W'(v_d[i]);
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= RESET_DATA;
         end
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain
//   Directed and random stimulus for pipe_reg_chain (WIDTH=8, DEPTH=4).
//   Accepted beats are queued as expected outputs; an independent monitor
//   pops and compares on every delivered beat and tracks occupancy/in_ready
//   with a FIFO-level model.
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       occupancy;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] exp_q [$];
   int unsigned      m_occ = 0;
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] stall_data = '0;

   pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for the model to report an empty chain
   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0 && m_occ == 0) break;
         step();
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor: samples on the falling edge, between driver updates
   always @(negedge clk) begin
      logic m_rdy;
      logic acc;
      logic del;
      logic [WIDTH-1:0] e;
      if (rst) begin
         chk("rst_in_ready", 32'(in_ready), 32'd0);
         exp_q.delete();
         m_occ      = 0;
         stall_prev = 1'b0;
      end else begin
         m_rdy = !flush && (m_occ != DEPTH || out_ready);
         chk("in_ready", 32'(in_ready), 32'(m_rdy));
         chk("occupancy", 32'(occupancy), m_occ);
         if (m_occ == 0)     chk("empty_out_valid", 32'(out_valid), 32'd0);
         if (m_occ == DEPTH) chk("full_out_valid", 32'(out_valid), 32'd1);
         if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(stall_data));
         end
         del = out_valid && out_ready;
         if (del) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h want none at %0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e));
            end
         end
         acc = in_valid && m_rdy;
         if (flush) begin
            exp_q.delete();
            m_occ      = 0;
            stall_prev = 1'b0;
         end else begin
            if (acc) exp_q.push_back(in_data);
            m_occ = m_occ + 32'(acc);
            if (del && m_occ > 0) m_occ = m_occ - 1;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_out;
      int outs;
      int idx;
      int accepts;

      // 1: reset with a beat offered
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_out_data", 32'(out_data), 32'h00);
      chk("t1_occupancy", 32'(occupancy), 32'd0);
      chk("t1_in_ready", 32'(in_ready), 32'd0);
      step();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // 2: stream 01..08, latency DEPTH cycles then one beat per cycle
      first_out = -1;
      outs      = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid = (cyc < 8);
         in_data  = 8'(cyc + 1);
         @(negedge clk);
         if (out_valid) begin
            if (first_out < 0) first_out = cyc;
            outs++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("t2_latency", 32'(first_out), 32'd4);
      chk("t2_out_count", 32'(outs), 32'd8);
      drain();

      // 3: stall fills all four stages, then release without a bubble
      out_ready = 1'b0;
      idx       = 0;
      accepts   = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + idx);
         @(negedge clk);
         if (in_ready) begin
            idx++;
            accepts++;
         end
         step();
      end
      in_data = 8'(8'h10 + idx);
      chk("t3_accepts", 32'(accepts), 32'd4);
      @(negedge clk);
      chk("t3_occupancy", 32'(occupancy), 32'd4);
      chk("t3_out_data", 32'(out_data), 32'h10);
      chk("t3_in_ready_full", 32'(in_ready), 32'd0);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_no_bubble", 32'(in_ready), 32'd1);
      for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (in_ready) idx++;
         step();
         in_data = 8'(8'h10 + idx);
      end
      in_valid = 1'b0;
      chk("t3_sent", 32'(idx), 32'd6);
      drain();

      // 4: two beats separated by idle cycles collapse at the output end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h21;
      step();
      in_valid = 1'b0;
      step();
      step();
      in_valid = 1'b1;
      in_data  = 8'h22;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("t4_occupancy", 32'(occupancy), 32'd2);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      chk("t4_out_data", 32'(out_data), 32'h21);
      step();
      out_ready = 1'b1;
      drain();

      // 5: flush a chain holding three beats while a beat is offered
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h31 + k);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("t5_occ_before", 32'(occupancy), 32'd3);
      step();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h34;
      @(negedge clk);
      chk("t5_flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_occupancy", 32'(occupancy), 32'd0);
      chk("t5_data_kept", 32'(out_data), 32'h31);
      step();
      out_ready = 1'b1;
      repeat (6) step();

      // 5b: flush while the output beat is being delivered
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h41 + k);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      repeat (4) step();
      chk("t5b_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset in mid-stream wins over transfers
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h51 + k);
         out_ready = 1'b0;
         step();
      end
      rst = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_out_data", 32'(out_data), 32'h00);
      chk("rst_mid_occupancy", 32'(occupancy), 32'd0);
      step();

      // 6: random traffic with occasional flush
      for (int cyc = 0; cyc < 2000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 99) == 0);
         in_data   = 8'($urandom);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
